// File: rtl/lag_tracker.sv
// Windowed lead/lag integrator behind the PDM cross-correlator.
// Steps a saturating signed lag estimate once per window, with hysteresis.
module lag_tracker #(
  parameter int MAX_LAG = 127,
  parameter int LAG_W   = 8,
  parameter int CNT_W   = 9,
  parameter int SUM_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sample_en,
  input  logic                    pos,
  input  logic                    neg,
  input  logic [7:0]              corr,
  input  logic [7:0]              window,
  input  logic [7:0]              thresh,
  input  logic                    lag_ready,
  output logic                    lag_valid,
  output logic signed [LAG_W-1:0] lag_out,
  output logic [1:0]              dir_out,
  output logic [SUM_W-1:0]        corr_sum,
  output logic                    dropped
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] DECIDE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic signed [LAG_W-1:0] LMAX = LAG_W'(MAX_LAG);
  localparam logic signed [LAG_W-1:0] LMIN = LAG_W'(-MAX_LAG);

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        win_q, win_d;
  logic [CNT_W-1:0]        pos_q, pos_d;
  logic [CNT_W-1:0]        neg_q, neg_d;
  logic [CNT_W-1:0]        smp_q, smp_d;
  logic [SUM_W-1:0]        acc_q, acc_d;
  logic signed [LAG_W-1:0] lag_q, lag_d;
  logic [1:0]              dir_q, dir_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic                    vld_q, vld_d;
  logic                    drp_q, drp_d;

  logic [CNT_W-1:0] win_ld;
  logic [CNT_W-1:0] smp_inc;
  logic [CNT_W:0]   p_ext;
  logic [CNT_W:0]   n_ext;
  logic [CNT_W:0]   t_ext;
  logic             go_up;
  logic             go_dn;

  // A zero window encodes 256 samples.
  assign win_ld  = (window == 8'd0) ? CNT_W'(256) : CNT_W'(window);
  assign smp_inc = smp_q + CNT_W'(1);

  // One extra bit so count + thresh cannot wrap.
  assign p_ext = {1'b0, pos_q};
  assign n_ext = {1'b0, neg_q};
  assign t_ext = (CNT_W+1)'(thresh);
  assign go_up = p_ext > (n_ext + t_ext);
  assign go_dn = n_ext > (p_ext + t_ext);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    smp_d   = smp_q;
    acc_d   = acc_q;
    lag_d   = lag_q;
    dir_d   = dir_q;
    sum_d   = sum_q;
    vld_d   = vld_q;
    drp_d   = drp_q;
    unique case (state_q)
      IDLE: begin
        pos_d = '0;
        neg_d = '0;
        smp_d = '0;
        acc_d = '0;
        if (en) begin
          state_d = ACCUM;
          win_d   = win_ld;
        end
      end
      ACCUM: begin
        if (!en) begin
          state_d = IDLE;
        end else if (sample_en) begin
          pos_d = pos_q + CNT_W'(pos);
          neg_d = neg_q + CNT_W'(neg);
          acc_d = acc_q + SUM_W'(corr);
          smp_d = smp_inc;
          if (smp_inc == win_q) state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (go_up) begin
          dir_d = 2'b01;
          if (lag_q != LMAX) lag_d = lag_q + LAG_W'(1);
        end else if (go_dn) begin
          dir_d = 2'b10;
          if (lag_q != LMIN) lag_d = lag_q - LAG_W'(1);
        end else begin
          dir_d = 2'b00;
        end
        sum_d   = acc_q;
        vld_d   = 1'b1;
        state_d = HOLD;
        if (sample_en && en) drp_d = 1'b1;
      end
      HOLD: begin
        if (sample_en && en) drp_d = 1'b1;
        if (lag_ready) begin
          vld_d   = 1'b0;
          pos_d   = '0;
          neg_d   = '0;
          smp_d   = '0;
          acc_d   = '0;
          win_d   = win_ld;
          state_d = en ? ACCUM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      smp_q   <= '0;
      acc_q   <= '0;
      lag_q   <= '0;
      dir_q   <= 2'b00;
      sum_q   <= '0;
      vld_q   <= 1'b0;
      drp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      smp_q   <= smp_d;
      acc_q   <= acc_d;
      lag_q   <= lag_d;
      dir_q   <= dir_d;
      sum_q   <= sum_d;
      vld_q   <= vld_d;
      drp_q   <= drp_d;
    end
  end

  assign lag_valid = vld_q;
  assign lag_out   = lag_q;
  assign dir_out   = dir_q;
  assign corr_sum  = sum_q;
  assign dropped   = drp_q;

endmodule

// File: tb/tb_lag_tracker.sv
// Bench for lag_tracker: vector table, corner sequences, random windows.
// Two instances share stimulus; the second saturates at +/-3.
module tb_lag_tracker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic sample_en = 1'b0;
  logic pos = 1'b0;
  logic neg = 1'b0;
  logic lag_ready = 1'b0;
  logic [7:0] corr = '0;
  logic [7:0] window = '0;
  logic [7:0] thresh = '0;

  logic              lv_a, lv_b, dr_a, dr_b;
  logic signed [7:0] lag_a, lag_b;
  logic [1:0]        dir_a, dir_b;
  logic [15:0]       sum_a, sum_b;

  lag_tracker u_a (
    .clk(clk), .rst(rst), .en(en), .sample_en(sample_en),
    .pos(pos), .neg(neg), .corr(corr), .window(window),
    .thresh(thresh), .lag_ready(lag_ready), .lag_valid(lv_a),
    .lag_out(lag_a), .dir_out(dir_a), .corr_sum(sum_a),
    .dropped(dr_a)
  );

  lag_tracker #(.MAX_LAG(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .sample_en(sample_en),
    .pos(pos), .neg(neg), .corr(corr), .window(window),
    .thresh(thresh), .lag_ready(lag_ready), .lag_valid(lv_b),
    .lag_out(lag_b), .dir_out(dir_b), .corr_sum(sum_b),
    .dropped(dr_b)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr = 0;
  int m_lag_a = 0;
  int m_lag_b = 0;
  int m_dir = 0;
  int m_sum = 0;
  int m_drop = 0;

  typedef struct {
    int w; int t; int p; int n; int b; int c;
    int dir; int lag; int sum;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic void model_decide(int p, int n, int t, int s);
    if (p > n + t) begin
      m_dir = 1;
      if (m_lag_a < 127) m_lag_a++;
      if (m_lag_b < 3) m_lag_b++;
    end else if (n > p + t) begin
      m_dir = 2;
      if (m_lag_a > -127) m_lag_a--;
      if (m_lag_b > -3) m_lag_b--;
    end else begin
      m_dir = 0;
    end
    m_sum = s;
  endfunction

  function automatic void model_reset();
    m_lag_a = 0; m_lag_b = 0; m_dir = 0; m_sum = 0; m_drop = 0;
  endfunction

  task automatic check_out();
    check("valid", int'(lv_a), 1);
    check("valid_sat", int'(lv_b), 1);
    check("lag", int'(lag_a), m_lag_a);
    check("lag_sat", int'(lag_b), m_lag_b);
    check("dir", int'(dir_a), m_dir);
    check("dir_sat", int'(dir_b), m_dir);
    check("corr_sum", int'(sum_a), m_sum);
    check("corr_sum_sat", int'(sum_b), m_sum);
    check("dropped", int'(dr_a), m_drop);
  endtask

  task automatic check_reset();
    check("rst_valid", int'(lv_a) + int'(lv_b), 0);
    check("rst_lag", int'(lag_a), 0);
    check("rst_lag_sat", int'(lag_b), 0);
    check("rst_dir", int'(dir_a) + int'(dir_b), 0);
    check("rst_sum", int'(sum_a) + int'(sum_b), 0);
    check("rst_dropped", int'(dr_a) + int'(dr_b), 0);
  endtask

  // kind 0: first b samples pos+neg, next p pos only, next n neg only.
  // kind 1: random flags/corr with random idle gaps.
  task automatic run_window(input int w, input int t, input int kind,
                            input int p, input int n, input int b,
                            input int c, input int junk, input int skip);
    int total;
    int cp;
    int cn;
    int cs;
    int cyc;
    total = (w == 0) ? 256 : w;
    cp = 0; cn = 0; cs = 0;
    window = 8'(w);
    thresh = 8'(t);
    en = 1'b1;
    lag_ready = 1'b0;
    sample_en = 1'b0;
    if (skip == 0) step();
    for (int i = 0; i < total; i++) begin
      if (kind == 1 && $urandom_range(3) == 0) begin
        sample_en = 1'b0;
        step();
      end
      if (kind == 0) begin
        pos = (i < b + p);
        neg = (i < b) || (i >= b + p && i < b + p + n);
        corr = 8'(c);
      end else begin
        pos = 1'($urandom_range(1));
        neg = 1'($urandom_range(1));
        corr = 8'($urandom_range(255));
      end
      sample_en = 1'b1;
      cp += int'(pos);
      cn += int'(neg);
      cs += int'(corr);
      step();
    end
    sample_en = (junk != 0);
    if (junk != 0) begin
      pos = 1'b0; neg = 1'b1; corr = 8'd200;
      m_drop = 1;
    end
    cyc = 0;
    while (!lv_a && cyc < 8) begin
      step();
      cyc++;
    end
    check("latency", cyc, 1);
    model_decide(cp, cn, t, cs);
    check_out();
  endtask

  task automatic release_en0();
    sample_en = 1'b0;
    en = 1'b0;
    lag_ready = 1'b1;
    step();
    lag_ready = 1'b0;
    check("valid_clear", int'(lv_a), 0);
  endtask

  initial begin
    tbl[0] = '{w:4, t:1,   p:4, n:0, b:0, c:10,  dir:1, lag:1,  sum:40};
    tbl[1] = '{w:8, t:2,   p:3, n:5, b:0, c:0,   dir:0, lag:1,  sum:0};
    tbl[2] = '{w:8, t:2,   p:2, n:6, b:0, c:3,   dir:2, lag:0,  sum:24};
    tbl[3] = '{w:2, t:0,   p:0, n:0, b:0, c:255, dir:0, lag:0,  sum:510};
    tbl[4] = '{w:3, t:0,   p:0, n:1, b:0, c:1,   dir:2, lag:-1, sum:3};
    tbl[5] = '{w:4, t:0,   p:1, n:0, b:3, c:7,   dir:1, lag:0,  sum:28};
    tbl[6] = '{w:5, t:255, p:5, n:0, b:0, c:2,   dir:0, lag:0,  sum:10};

    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    check_reset();

    foreach (tbl[i]) begin
      run_window(tbl[i].w, tbl[i].t, 0, tbl[i].p, tbl[i].n,
                 tbl[i].b, tbl[i].c, 0, 0);
      check("tbl_dir", int'(dir_a), tbl[i].dir);
      check("tbl_lag", int'(lag_a), tbl[i].lag);
      check("tbl_sum", int'(sum_a), tbl[i].sum);
      release_en0();
    end

    // Saturation on the MAX_LAG=3 instance.
    for (int i = 0; i < 6; i++) begin
      run_window(1, 0, 0, 1, 0, 0, 0, 0, 0);
      check("sat_lag", int'(lag_b), (i < 3) ? i + 1 : 3);
      check("sat_dir", int'(dir_b), 1);
      release_en0();
    end

    // Samples while idle are ignored without flagging.
    en = 1'b0;
    sample_en = 1'b1;
    pos = 1'b1;
    repeat (3) step();
    sample_en = 1'b0;
    check("idle_dropped", int'(dr_a), 0);
    check("idle_valid", int'(lv_a), 0);

    // Abort after 3 of 8 samples, then a clean window.
    window = 8'd8; thresh = 8'd0; en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; pos = 1'b1; neg = 1'b0; corr = 8'd50;
      step();
    end
    sample_en = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_valid", int'(lv_a), 0);
    end
    run_window(8, 0, 0, 0, 8, 0, 2, 0, 0);
    check("abort_sum", int'(sum_a), 16);
    release_en0();

    // en=0 beats a completing sample.
    window = 8'd2; en = 1'b1;
    step();
    sample_en = 1'b1; corr = 8'd9;
    step();
    en = 1'b0;
    step();
    sample_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("enwin_no_valid", int'(lv_a), 0);
    end

    for (int k = 0; k < 30; k++) begin
      run_window($urandom_range(1, 12), $urandom_range(0, 3),
                 1, 0, 0, 0, 0, 0, 0);
      release_en0();
    end

    // Stalled handshake with samples arriving in DECIDE/HOLD.
    run_window(4, 0, 0, 4, 0, 0, 5, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", int'(lv_a), 1);
      check("hold_lag", int'(lag_a), m_lag_a);
      check("hold_sum", int'(sum_a), m_sum);
    end
    check("hold_dropped", int'(dr_a), 1);
    en = 1'b1;
    lag_ready = 1'b1;
    step();
    lag_ready = 1'b0;
    sample_en = 1'b0;
    check("hs_valid_clear", int'(lv_a), 0);
    run_window(4, 0, 0, 4, 0, 0, 1, 0, 1);
    check("post_hs_sum", int'(sum_a), 4);
    release_en0();

    // 256-sample window.
    run_window(0, 0, 0, 200, 56, 0, 255, 0, 0);
    check("w256_sum", int'(sum_a), 65280);
    release_en0();

    // Reset mid-window.
    window = 8'd0; en = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      sample_en = 1'b1; pos = 1'b1; corr = 8'd1;
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    en = 1'b0;
    sample_en = 1'b0;
    model_reset();
    check_reset();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
